// File: rtl/pulse_pattern_tx.sv
// ============================================================================
// Module   : pulse_pattern_tx
// Purpose  : Programmable per-channel test-pulse generator driving the
//            differential channel pairs of the coincidence detector.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_pattern_tx #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [CNT_W-1:0]      period,
    input  logic [CNT_W-1:0]      width,
    input  logic [N_CH*CNT_W-1:0] delay,
    input  logic [CNT_W-1:0]      burst_count,
    input  logic [N_CH-1:0]       ch_enable,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      periods_done,
    output logic [2*N_CH-1:0]     DS_Channels
);

    localparam logic [CNT_W-1:0] c_min_period = CNT_W'(2);
    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [CNT_W-1:0]        r_period_eff;
    logic [CNT_W-1:0]        r_width;
    logic [N_CH*CNT_W-1:0]   r_delay;
    logic [CNT_W-1:0]        r_burst;
    logic [N_CH-1:0]         r_en;

    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        r_periods_done;
    logic                    r_busy;
    logic                    r_done;
    logic [N_CH-1:0]         r_ch_q;

    logic                    w_launch;
    logic                    w_abort;
    logic                    w_wrap;
    logic                    w_burst_end;
    logic [CNT_W-1:0]        w_pd_inc;
    logic [CNT_W-1:0]        w_pd_next;
    logic [N_CH-1:0]         w_hit;

    assign w_wrap    = (r_cnt == r_period_eff - c_one);
    assign w_pd_inc  = r_periods_done + c_one;
    // Saturate so a long continuous run never appears to restart at zero
    assign w_pd_next = (r_periods_done == '1) ? r_periods_done : w_pd_inc;

    // Window compare at CNT_W+1 bits; cnt never reaches eff_period so
    // windows are naturally truncated at the period end.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_window
            logic [CNT_W:0] w_lo;
            logic [CNT_W:0] w_hi;
            logic [CNT_W:0] w_pos;
            assign w_lo      = {1'b0, r_delay[gi*CNT_W +: CNT_W]};
            assign w_hi      = w_lo + {1'b0, r_width};
            assign w_pos     = {1'b0, r_cnt};
            assign w_hit[gi] = r_en[gi] && (r_width != '0) &&
                               (w_pos >= w_lo) && (w_pos < w_hi);
        end
    endgenerate

    always_comb begin
        w_next_state = r_state;
        w_launch     = 1'b0;
        w_abort      = 1'b0;
        w_burst_end  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_launch     = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_abort      = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_wrap && (r_burst != '0) && (w_pd_inc == r_burst)) begin
                    w_burst_end  = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period_eff   <= c_min_period;
            r_width        <= '0;
            r_delay        <= '0;
            r_burst        <= '0;
            r_en           <= '0;
            r_cnt          <= '0;
            r_periods_done <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_ch_q         <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_launch) begin
                r_period_eff   <= (period < c_min_period) ? c_min_period : period;
                r_width        <= width;
                r_delay        <= delay;
                r_burst        <= burst_count;
                r_en           <= ch_enable;
                r_cnt          <= '0;
                r_periods_done <= '0;
                r_busy         <= 1'b1;
                r_ch_q         <= '0;
            end else if (r_state == S_RUN) begin
                if (w_abort) begin
                    r_busy <= 1'b0;
                    r_ch_q <= '0;
                end else begin
                    r_cnt <= w_wrap ? '0 : r_cnt + c_one;
                    if (w_wrap) begin
                        r_periods_done <= w_pd_next;
                    end
                    if (w_burst_end) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_ch_q <= '0;
                    end else begin
                        r_ch_q <= w_hit;
                    end
                end
            end
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign periods_done = r_periods_done;

    // Differential output stage (OBUFDS equivalent): P = ch_q, N = ~ch_q
    generate
        for (genvar gj = 0; gj < N_CH; gj++) begin : g_obufds
            assign DS_Channels[2*gj]   = r_ch_q[gj];
            assign DS_Channels[2*gj+1] = ~r_ch_q[gj];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pulse_pattern_tx.sv
// ============================================================================
// Module   : tb_pulse_pattern_tx
// Purpose  : Directed self-checking bench for pulse_pattern_tx.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pulse_pattern_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] period;
    logic [15:0] width;
    logic [63:0] delay;
    logic [15:0] burst_count;
    logic [3:0]  ch_enable;
    logic        busy;
    logic        done;
    logic [15:0] periods_done;
    logic [7:0]  DS_Channels;

    int n_vec = 0;
    int n_err = 0;

    pulse_pattern_tx #(.N_CH(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .period       (period),
        .width        (width),
        .delay        (delay),
        .burst_count  (burst_count),
        .ch_enable    (ch_enable),
        .busy         (busy),
        .done         (done),
        .periods_done (periods_done),
        .DS_Channels  (DS_Channels)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ds_of(input logic [3:0] q);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) begin
            r[2*i]   = q[i];
            r[2*i+1] = ~q[i];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic cfg_basic();
        period = 16'd10; width = 16'd3; delay = {16'd0, 16'd0, 16'd0, 16'd2};
        burst_count = 16'd1; ch_enable = 4'b0001;
    endtask

    task automatic test_reset();
        n_vec++;
        if (DS_Channels !== 8'hAA) begin n_err++; $display("FAIL reset_ds got %h want %h", DS_Channels, 8'hAA); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_vec++;
        if (periods_done !== 16'd0) begin n_err++; $display("FAIL reset_pd got %0d want 0", periods_done); end
    endtask

    task automatic test_basic();
        logic [3:0] q;
        cfg_basic();
        launch();
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_e0 got %b want 1", busy); end
        for (int k = 1; k <= 12; k++) begin
            tick();
            q = (k >= 3 && k <= 5) ? 4'b0001 : 4'b0000;
            n_vec++;
            if (DS_Channels !== ds_of(q)) begin n_err++; $display("FAIL basic_ds k=%0d got %h want %h", k, DS_Channels, ds_of(q)); end
            n_vec++;
            if (done !== (k == 10)) begin n_err++; $display("FAIL basic_done k=%0d got %b want %b", k, done, (k == 10)); end
        end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_end got %b want 0", busy); end
        n_vec++;
        if (periods_done !== 16'd1) begin n_err++; $display("FAIL basic_pd got %0d want 1", periods_done); end
    endtask

    task automatic test_multi();
        int hi[4];
        int done_n, done_k, ch3_run;
        logic prev3;
        period = 16'd8; width = 16'd2; delay = {16'd7, 16'd4, 16'd1, 16'd0};
        burst_count = 16'd3; ch_enable = 4'b1111;
        for (int i = 0; i < 4; i++) hi[i] = 0;
        done_n = 0; done_k = -1; ch3_run = 0; prev3 = 1'b0;
        launch();
        for (int k = 1; k <= 30; k++) begin
            tick();
            for (int i = 0; i < 4; i++) if (DS_Channels[2*i]) hi[i]++;
            if (prev3 && DS_Channels[6]) ch3_run++;
            prev3 = DS_Channels[6];
            if (done) begin done_n++; done_k = k; end
            n_vec++;
            if (DS_Channels[7:6] === 2'b00 || DS_Channels[7:6] === 2'b11) begin
                n_err++; $display("FAIL multi_pair3 k=%0d got %b want complementary", k, DS_Channels[7:6]);
            end
        end
        // ch3 pulse of the final period coincides with the burst-end edge and is cleared
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (hi[i] != ((i == 3) ? 2 : 6)) begin n_err++; $display("FAIL multi_hi ch%0d got %0d want %0d", i, hi[i], (i == 3) ? 2 : 6); end
        end
        n_vec++;
        if (ch3_run != 0) begin n_err++; $display("FAIL multi_ch3_trunc got %0d want 0", ch3_run); end
        n_vec++;
        if (done_n != 1) begin n_err++; $display("FAIL multi_done_n got %0d want 1", done_n); end
        n_vec++;
        if (done_k != 24) begin n_err++; $display("FAIL multi_done_k got %0d want 24", done_k); end
        n_vec++;
        if (periods_done !== 16'd3) begin n_err++; $display("FAIL multi_pd got %0d want 3", periods_done); end
    endtask

    task automatic test_degenerate();
        logic [15:0] pv;
        for (int p = 0; p < 2; p++) begin
            pv = 16'(p);
            period = pv; width = 16'd1; delay = 64'd0; burst_count = 16'd1; ch_enable = 4'b0001;
            launch();
            tick();
            n_vec++;
            if (DS_Channels !== ds_of(4'b0001)) begin n_err++; $display("FAIL degen_p%0d_k1 got %h want %h", p, DS_Channels, ds_of(4'b0001)); end
            n_vec++;
            if (done !== 1'b0) begin n_err++; $display("FAIL degen_p%0d_done1 got %b want 0", p, done); end
            tick();
            n_vec++;
            if (DS_Channels !== 8'hAA) begin n_err++; $display("FAIL degen_p%0d_k2 got %h want aa", p, DS_Channels); end
            n_vec++;
            if (done !== 1'b1) begin n_err++; $display("FAIL degen_p%0d_done2 got %b want 1", p, done); end
        end
        period = 16'd4; width = 16'd0; delay = 64'd0; burst_count = 16'd2; ch_enable = 4'b1111;
        launch();
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_vec++;
            if (DS_Channels !== 8'hAA || busy !== (k < 8) || done !== (k == 8)) begin
                n_err++; $display("FAIL degen_w0 k=%0d got ds=%h busy=%b done=%b want ds=aa busy=%b done=%b",
                                  k, DS_Channels, busy, done, (k < 8), (k == 8));
            end
        end
        period = 16'd10; width = 16'd3; delay = {16'd0, 16'd0, 16'd0, 16'd20}; burst_count = 16'd1; ch_enable = 4'b0001;
        launch();
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_vec++;
            if (DS_Channels !== 8'hAA || done !== (k == 10)) begin
                n_err++; $display("FAIL degen_d20 k=%0d got ds=%h done=%b want ds=aa done=%b", k, DS_Channels, done, (k == 10));
            end
        end
    endtask

    task automatic test_continuous_stop();
        logic [3:0] q;
        period = 16'd5; width = 16'd1; delay = 64'd0; burst_count = 16'd0; ch_enable = 4'b0001;
        launch();
        for (int k = 1; k <= 23; k++) begin
            tick();
            q = (((k - 1) % 5) == 0) ? 4'b0001 : 4'b0000;
            n_vec++;
            if (DS_Channels !== ds_of(q) || busy !== 1'b1 || done !== 1'b0) begin
                n_err++; $display("FAIL cont k=%0d got ds=%h busy=%b done=%b want ds=%h busy=1 done=0",
                                  k, DS_Channels, busy, done, ds_of(q));
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy got %b want 0", busy); end
        n_vec++;
        if (DS_Channels !== 8'hAA) begin n_err++; $display("FAIL stop_ds got %h want aa", DS_Channels); end
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL stop_done got %b want 0", done); end
        n_vec++;
        if (periods_done !== 16'd4) begin n_err++; $display("FAIL stop_pd got %0d want 4", periods_done); end
        tick();
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL stop_idle got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_simultaneous();
        logic [3:0] q;
        cfg_basic();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        tick();
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL simul_busy got %b want 0", busy); end
        n_vec++;
        if (periods_done !== 16'd4) begin n_err++; $display("FAIL simul_pd got %0d want 4", periods_done); end
        launch();
        for (int k = 1; k <= 12; k++) begin
            tick();
            q = (k >= 3 && k <= 5) ? 4'b0001 : 4'b0000;
            n_vec++;
            if (DS_Channels !== ds_of(q) || done !== (k == 10)) begin
                n_err++; $display("FAIL simul_run k=%0d got ds=%h done=%b want ds=%h done=%b", k, DS_Channels, done, ds_of(q), (k == 10));
            end
            if (k == 2) begin
                start = 1'b1; period = 16'd4; width = 16'd5; delay = 64'd0;
                burst_count = 16'd0; ch_enable = 4'b1111;
            end
            if (k == 3) start = 1'b0;
        end
        n_vec++;
        if (periods_done !== 16'd1) begin n_err++; $display("FAIL simul_pd_end got %0d want 1", periods_done); end
    endtask

    task automatic test_reset_midrun();
        period = 16'd3; width = 16'd2; delay = 64'd0; burst_count = 16'd0; ch_enable = 4'b0001;
        launch();
        repeat (4) tick();
        n_vec++;
        if (DS_Channels !== ds_of(4'b0001) || periods_done !== 16'd1) begin
            n_err++; $display("FAIL rstmid_pre got ds=%h pd=%0d want ds=%h pd=1", DS_Channels, periods_done, ds_of(4'b0001));
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (DS_Channels !== 8'hAA) begin n_err++; $display("FAIL rstmid_ds got %h want aa", DS_Channels); end
        n_vec++;
        if (busy !== 1'b0 || periods_done !== 16'd0 || done !== 1'b0) begin
            n_err++; $display("FAIL rstmid_ctl got busy=%b pd=%0d done=%b want 0 0 0", busy, periods_done, done);
        end
        #2 rst = 1'b0;
        tick();
        cfg_basic();
        launch();
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_vec++;
            if (done !== (k == 10) || DS_Channels[0] !== (k >= 3 && k <= 5)) begin
                n_err++; $display("FAIL rstmid_rerun k=%0d got done=%b p0=%b want done=%b p0=%b",
                                  k, done, DS_Channels[0], (k == 10), (k >= 3 && k <= 5));
            end
        end
        n_vec++;
        if (periods_done !== 16'd1 || busy !== 1'b0) begin
            n_err++; $display("FAIL rstmid_end got pd=%0d busy=%b want 1 0", periods_done, busy);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        period = 16'd0; width = 16'd0; delay = 64'd0; burst_count = 16'd0; ch_enable = 4'b0000;
        repeat (2) tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_basic();
        test_multi();
        test_degenerate();
        test_continuous_stop();
        test_simultaneous();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
